i2c_bert_cmd_sched: RTL and testbench
=====================================

# i2c_bert_cmd_sched

Command scheduler between the two command sources of the I2C BERT design and its single shared test engine. Source A is the I2C target's decoded command byte stream. Source B is the configuration path fed from the `ena`/`rst_n` latched pin bits. The block arbitrates the sources round-robin, expands each command into N engine operations and XOR-accumulates the engine results. It returns one tagged response byte per command and enforces a per-operation watchdog.

## Interface

**Parameters**
- `TMO_W`, default 8: watchdog counter width; timeout limit is `2^TMO_W - 1` cycles.

**Ports**
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `ena` in 1: when low, no new command is accepted; an in-flight command completes.
- `a_cmd_valid` in 1, `a_cmd_ready` out 1, `a_cmd_data` in 8: source A (I2C) command.
- `b_cmd_valid` in 1, `b_cmd_ready` out 1, `b_cmd_data` in 8: source B (latched config) command.
- `eng_start` out 1: one-cycle start pulse to the engine.
- `eng_op` out 4: engine opcode, stable from `eng_start` until `eng_done`.
- `eng_busy` in 1: engine cannot accept a start.
- `eng_done` in 1: one-cycle completion strobe.
- `eng_result` in 8: result byte, valid with `eng_done`.
- `rsp_valid` out 1, `rsp_ready` in 1, `rsp_data` out 8: response.
- `rsp_src` out 1: response owner, 0 = A, 1 = B.
- `err` out 1: one-cycle pulse on watchdog timeout.

## Operation

**Command byte**
- `[7:4]` = op, `[3:0]` = n. The engine is run n+1 times (1..16).

**States:** IDLE, ISSUE, WAIT, RESP.

**IDLE**
- Grant:
  - Only A valid: A is granted.
  - Only B valid: B is granted.
  - Both valid: the source not granted last is granted.
- `x_cmd_ready` = (IDLE && `ena` && grant_x). This is combinational, and at most one ready is high.
- On a handshake:
  - latch op, remaining = n, src, acc = 0;
  - update last_grant;
  - go to ISSUE.

**ISSUE**
- `eng_start` = (ISSUE && !`eng_busy`).
- When `eng_start` is high: clear the watchdog and go to WAIT.
- While busy: stay in ISSUE. The watchdog does not run here.

**WAIT**
- Watchdog increments every cycle.
- On `eng_done`, acc ^= `eng_result`, then:
  - remaining == 0: go to RESP;
  - otherwise: remaining -= 1 and go to ISSUE.
- Watchdog reaching its limit without `eng_done`:
  - acc = 8'hFF;
  - pulse `err`;
  - go to RESP;
  - remaining operations are abandoned.
- `eng_done` in the limit cycle takes priority over the timeout.

**RESP**
- `rsp_valid` = 1, `rsp_data` = acc, `rsp_src` = src. All are held stable until `rsp_ready`.
- On `rsp_valid && rsp_ready`: go to IDLE.

**Other behaviour**
- `eng_done` outside WAIT is ignored.
- `ena` falling outside IDLE has no effect on the in-flight command.

**Reset values (all outputs)**
- State IDLE, last_grant = B (so A wins the first tie).
- Outputs `eng_start`, `eng_op`, `rsp_valid`, `rsp_data`, `rsp_src` and `err` all 0.
- Reset mid-command drops the command; no response is produced.

## Timing

- Handshake in cycle T → ISSUE in T+1. `eng_start` is high in T+1 if the engine is idle.
- Earliest `eng_done` is T+2. For n = 0, `rsp_valid` rises in T+3.
- Each additional operation costs at least 2 cycles: ISSUE 1 + WAIT ≥ 1.
- `rsp_ready` high in the first RESP cycle → IDLE next cycle. The next command can be accepted in that cycle, so the minimum back-to-back command interval is 4 cycles.
- Timeout: `err` and the RESP entry occur on the edge after the watchdog reaches `2^TMO_W - 1`, i.e. 255 WAIT cycles at the default.
- `err` is registered and high for exactly one cycle.

## Test plan

- **Single A command, n = 0:** A sends 8'h30, engine done 1 cycle after start with result 8'h5A → `eng_op` = 3; `rsp_data` = 8'h5A, `rsp_src` = 0, `rsp_valid` at T+3.
- **Repeat count:** B sends 8'h12, engine results 8'h01, 8'h02, 8'h04 → exactly 3 `eng_start` pulses; `rsp_data` = 8'h07, `rsp_src` = 1.
- **Arbitration:** A and B both valid continuously after reset → grant order A, B, A, B; one response per grant, in order.
- **Busy stall and backpressure:** `eng_busy` held for 5 cycles in ISSUE, then `rsp_ready` held low for 10 cycles → no `eng_start` while busy; `rsp_data`/`rsp_src` stable; no new ready while in RESP.
- **Timeout:** engine never signals done, `TMO_W` = 4 → `err` pulses once 15 WAIT cycles after start; `rsp_data` = 8'hFF. The next command then runs normally.
- **Gating and reset:**
  - `ena` low with A valid → `a_cmd_ready` stays 0.
  - `rst_n` low during WAIT → next cycle IDLE with all outputs 0; a stale `eng_done` is ignored.
  - A first tie after reset is won by A.

Source files
------------

// File: rtl/i2c_bert_cmd_sched.sv
// i2c_bert_cmd_sched: arbitrates the I2C (A) and latched-config (B)
// command sources onto the shared BERT engine.
//
// Each command byte {op, n} runs the engine n+1 times. The results are
// XOR-accumulated and returned as one tagged response byte.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   ena                  gates acceptance of new commands
//   a_cmd_*              source A valid/ready/data handshake
//   b_cmd_*              source B valid/ready/data handshake
//   eng_start/eng_op     start pulse and opcode to the engine
//   eng_busy/eng_done    engine status and completion strobe
//   eng_result           engine result byte, valid with eng_done
//   rsp_*                response valid/ready/data and source tag (1 = B)
//   err                  one-cycle pulse on a watchdog timeout
module i2c_bert_cmd_sched #(
    parameter int TMO_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       a_cmd_valid,
    output logic       a_cmd_ready,
    input  logic [7:0] a_cmd_data,
    input  logic       b_cmd_valid,
    output logic       b_cmd_ready,
    input  logic [7:0] b_cmd_data,
    output logic       eng_start,
    output logic [3:0] eng_op,
    input  logic       eng_busy,
    input  logic       eng_done,
    input  logic [7:0] eng_result,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_src,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [TMO_W-1:0] WD_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0] WD_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        op_q;
    logic [3:0]        rem_q;
    logic              src_q;
    logic              last_b_q;
    logic [7:0]        acc_q;
    logic [TMO_W-1:0]  wdog_q;
    logic              err_q;
    logic              grant_a;
    logic              grant_b;
    logic              take;
    logic              tmo;
    logic [7:0]        cmd;

    // B only wins a tie when A had the previous grant.
    assign grant_a = a_cmd_valid && (!b_cmd_valid || last_b_q);
    assign grant_b = b_cmd_valid && !grant_a;
    assign take    = a_cmd_ready || b_cmd_ready;
    assign cmd     = b_cmd_ready ? b_cmd_data : a_cmd_data;

    // wdog_q holds the number of WAIT cycles already elapsed, so the
    // cycle in which it reads 2^TMO_W-2 is WAIT cycle 2^TMO_W-1, the
    // last one allowed. A done strobe in that cycle still wins.
    assign tmo = (state == WAIT) && !eng_done && (wdog_q == WD_LAST);

    assign eng_op   = op_q;
    assign rsp_data = acc_q;
    assign rsp_src  = src_q;
    assign err      = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (take) state_nxt = ISSUE;
            ISSUE:   if (eng_start) state_nxt = WAIT;
            WAIT: begin
                if (eng_done)
                    state_nxt = (rem_q == 4'd0) ? RESP : ISSUE;
                else if (tmo)
                    state_nxt = RESP;
            end
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        a_cmd_ready = 1'b0;
        b_cmd_ready = 1'b0;
        eng_start   = 1'b0;
        rsp_valid   = 1'b0;
        unique case (state)
            IDLE: begin
                a_cmd_ready = ena && grant_a;
                b_cmd_ready = ena && grant_b;
            end
            ISSUE:   eng_start = !eng_busy;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= '0;
            rem_q    <= '0;
            src_q    <= 1'b0;
            last_b_q <= 1'b1;
            acc_q    <= '0;
            wdog_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= tmo;
            unique case (state)
                IDLE: begin
                    if (take) begin
                        op_q     <= cmd[7:4];
                        rem_q    <= cmd[3:0];
                        src_q    <= b_cmd_ready;
                        last_b_q <= b_cmd_ready;
                        acc_q    <= '0;
                    end
                end
                ISSUE: begin
                    if (eng_start) wdog_q <= '0;
                end
                WAIT: begin
                    wdog_q <= wdog_q + WD_ONE;
                    if (eng_done) begin
                        acc_q <= acc_q ^ eng_result;
                        if (rem_q != 4'd0) rem_q <= rem_q - 4'd1;
                    end else if (tmo) begin
                        acc_q <= 8'hFF;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bert_cmd_sched.sv
// tb_i2c_bert_cmd_sched: self-checking bench for i2c_bert_cmd_sched.
// Reactive engine model, table vectors, directed sequences, random run.
module tb_i2c_bert_cmd_sched;

    localparam int TW  = 4;
    localparam int LIM = (1 << TW) - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       a_cmd_valid = 1'b0;
    logic [7:0] a_cmd_data = 8'h00;
    logic       b_cmd_valid = 1'b0;
    logic [7:0] b_cmd_data = 8'h00;
    logic       eng_busy = 1'b0;
    logic       eng_done = 1'b0;
    logic [7:0] eng_result = 8'h00;
    logic       rsp_ready = 1'b1;
    logic       a_cmd_ready;
    logic       b_cmd_ready;
    logic       eng_start;
    logic [3:0] eng_op;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_src;
    logic       err;

    i2c_bert_cmd_sched #(.TMO_W(TW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .a_cmd_valid (a_cmd_valid),
        .a_cmd_ready (a_cmd_ready),
        .a_cmd_data  (a_cmd_data),
        .b_cmd_valid (b_cmd_valid),
        .b_cmd_ready (b_cmd_ready),
        .b_cmd_data  (b_cmd_data),
        .eng_start   (eng_start),
        .eng_op      (eng_op),
        .eng_busy    (eng_busy),
        .eng_done    (eng_done),
        .eng_result  (eng_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_src     (rsp_src),
        .err         (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // stimulus knobs
    bit rnd  = 1'b0;
    bit hang = 1'b0;
    int dly  = 1;
    int pend = 0;
    int busy_left = 0;
    int rsp_lo = 0;
    int a_left = 0;
    int b_left = 0;
    logic [7:0] res_q[$];

    // reference model of the command in flight
    bit         busy_m = 1'b0;
    bit         last_b = 1'b1;
    bit         m_src = 1'b0;
    bit         m_tmo = 1'b0;
    logic [3:0] m_op = 4'h0;
    logic [3:0] m_n = 4'h0;
    logic [7:0] m_acc = 8'h00;
    int         m_starts = 0;
    bit         prev_hold = 1'b0;
    bit         prev_rv = 1'b0;
    logic [7:0] prev_data = 8'h00;
    bit         prev_src = 1'b0;

    // event logs (cycle numbers / values)
    int acc_l[$];
    int src_l[$];
    int start_l[$];
    int op_l[$];
    int rise_l[$];
    int hs_l[$];
    int rdat_l[$];
    int err_l[$];

    typedef struct {
        bit av;
        bit bv;
        bit en;
        bit ea;
        bit eb;
    } vec_t;
    vec_t vt[6];

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_logs();
        acc_l.delete();
        src_l.delete();
        start_l.delete();
        op_l.delete();
        rise_l.delete();
        hs_l.delete();
        rdat_l.delete();
        err_l.delete();
    endtask

    // One clock cycle: drive inputs, observe settled outputs, clock.
    task automatic tick();
        bit ga;
        bit gb;
        bit ac_a;
        bit ac_b;
        if (rnd) begin
            a_cmd_valid = 1'($urandom_range(0, 1));
            a_cmd_data  = 8'($urandom);
            b_cmd_valid = 1'($urandom_range(0, 1));
            b_cmd_data  = 8'($urandom);
            ena         = ($urandom_range(0, 7) != 0);
            rsp_ready   = 1'($urandom_range(0, 1));
            eng_busy    = ($urandom_range(0, 3) == 0);
        end else begin
            a_cmd_valid = (a_left > 0);
            b_cmd_valid = (b_left > 0);
            rsp_ready   = (rsp_lo == 0);
            eng_busy    = (busy_left > 0);
            if (busy_left > 0) busy_left--;
        end
        eng_done   = 1'b0;
        eng_result = 8'($urandom);
        if (pend > 0) begin
            pend--;
            if (pend == 0 && !hang) begin
                eng_done   = 1'b1;
                eng_result = (res_q.size() > 0) ? res_q.pop_front() : 8'($urandom);
            end
        end
        #1;
        if (rst_n) begin
            ga = a_cmd_valid && (!b_cmd_valid || last_b);
            gb = b_cmd_valid && !ga;
            chk("a_ready", int'(a_cmd_ready), int'(!busy_m && ena && ga));
            chk("b_ready", int'(b_cmd_ready), int'(!busy_m && ena && gb));
            if (!busy_m) chk("idle_rsp_valid", int'(rsp_valid), 0);
            if (eng_busy) chk("start_while_busy", int'(eng_start), 0);
            if (prev_hold) begin
                chk("hold_valid", int'(rsp_valid), 1);
                chk("hold_data", int'(rsp_data), int'(prev_data));
                chk("hold_src", int'(rsp_src), int'(prev_src));
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_data = rsp_data;
            prev_src  = rsp_src;
            if (rsp_valid && !prev_rv) rise_l.push_back(cyc);
            prev_rv = rsp_valid;
            if (eng_done && busy_m) begin
                chk("op_at_done", int'(eng_op), int'(m_op));
                m_acc ^= eng_result;
            end
            if (eng_start) begin
                chk("op_at_start", int'(eng_op), int'(m_op));
                m_starts++;
                start_l.push_back(cyc);
                op_l.push_back(int'(eng_op));
                pend = rnd ? int'($urandom_range(1, 4)) : dly;
            end
            if (err) err_l.push_back(cyc);
            if (rsp_valid && rsp_ready && busy_m) begin
                chk("rsp_data", int'(rsp_data), m_tmo ? 255 : int'(m_acc));
                chk("rsp_src", int'(rsp_src), int'(m_src));
                if (!m_tmo) chk("op_count", m_starts, int'(m_n) + 1);
                hs_l.push_back(cyc);
                rdat_l.push_back(int'(rsp_data));
                busy_m = 1'b0;
            end
            if (rsp_valid && rsp_lo > 0) rsp_lo--;
            ac_a = a_cmd_valid && a_cmd_ready;
            ac_b = b_cmd_valid && b_cmd_ready;
            if (ac_a || ac_b) begin
                busy_m   = 1'b1;
                m_src    = ac_b;
                last_b   = ac_b;
                m_op     = ac_b ? b_cmd_data[7:4] : a_cmd_data[7:4];
                m_n      = ac_b ? b_cmd_data[3:0] : a_cmd_data[3:0];
                m_acc    = 8'h00;
                m_starts = 0;
                m_tmo    = !rnd && (hang || dly > LIM);
                acc_l.push_back(cyc);
                src_l.push_back(int'(ac_b));
                if (ac_a && a_left > 0) a_left--;
                if (ac_b && b_left > 0) b_left--;
            end
        end else if (eng_start) begin
            pend = dly;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        chk("rst_eng_start", int'(eng_start), 0);
        chk("rst_eng_op", int'(eng_op), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_rsp_src", int'(rsp_src), 0);
        chk("rst_err", int'(err), 0);
        busy_m    = 1'b0;
        last_b    = 1'b1;
        prev_hold = 1'b0;
        prev_rv   = 1'b0;
        rst_n     = 1'b1;
    endtask

    task automatic run_until(input int nrsp, input int budget, input string nm);
        int k = 0;
        while (rdat_l.size() < nrsp && k < budget) begin
            tick();
            k++;
        end
        chk(nm, rdat_l.size(), nrsp);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "global timeout");
    end

    initial begin
        vt[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        @(posedge clk);
        #1;
        do_reset();

        // combinational ready in IDLE right after reset (A wins ties)
        for (int i = 0; i < 6; i++) begin
            a_cmd_valid = vt[i].av;
            b_cmd_valid = vt[i].bv;
            ena         = vt[i].en;
            #1;
            chk($sformatf("tbl%0d_a", i), int'(a_cmd_ready), int'(vt[i].ea));
            chk($sformatf("tbl%0d_b", i), int'(b_cmd_ready), int'(vt[i].eb));
        end
        a_cmd_valid = 1'b0;
        b_cmd_valid = 1'b0;
        ena = 1'b1;

        // single A command, n = 0
        clear_logs();
        dly = 1;
        res_q.push_back(8'h5A);
        a_cmd_data = 8'h30;
        a_left = 1;
        run_until(1, 30, "t1_done");
        chk("t1_src", qat(src_l, 0), 0);
        chk("t1_nstart", start_l.size(), 1);
        chk("t1_start_cyc", qat(start_l, 0), qat(acc_l, 0) + 1);
        chk("t1_op", qat(op_l, 0), 3);
        chk("t1_rise_cyc", qat(rise_l, 0), qat(acc_l, 0) + 3);
        chk("t1_data", qat(rdat_l, 0), 'h5A);

        // repeat count from B
        clear_logs();
        res_q.push_back(8'h01);
        res_q.push_back(8'h02);
        res_q.push_back(8'h04);
        b_cmd_data = 8'h12;
        b_left = 1;
        run_until(1, 40, "t2_done");
        chk("t2_nstart", start_l.size(), 3);
        chk("t2_data", qat(rdat_l, 0), 'h07);
        chk("t2_src", qat(src_l, 0), 1);

        // arbitration with both sources valid continuously
        do_reset();
        clear_logs();
        a_cmd_data = 8'h40;
        b_cmd_data = 8'h50;
        a_left = 2;
        b_left = 2;
        run_until(4, 80, "t3_done");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_src%0d", i), qat(src_l, i), i % 2);
            chk($sformatf("t3_op%0d", i), qat(op_l, i), (i % 2 == 0) ? 4 : 5);
        end
        chk("t3_interval", qat(acc_l, 1) - qat(acc_l, 0), 4);

        // busy stall then response backpressure
        clear_logs();
        a_cmd_data = 8'h60;
        b_cmd_data = 8'h70;
        busy_left = 6;
        rsp_lo = 10;
        a_left = 1;
        b_left = 1;
        run_until(2, 100, "t4_done");
        chk("t4_first_src", qat(src_l, 0), 0);
        chk("t4_start_cyc", qat(start_l, 0), qat(acc_l, 0) + 6);
        chk("t4_hs_cyc", qat(hs_l, 0), qat(rise_l, 0) + 10);
        chk("t4_next_acc", qat(acc_l, 1), qat(hs_l, 0) + 1);

        // watchdog timeout abandons remaining ops
        clear_logs();
        hang = 1'b1;
        dly = 1;
        a_cmd_data = 8'h82;
        a_left = 1;
        run_until(1, 60, "t5_done");
        chk("t5_nerr", err_l.size(), 1);
        chk("t5_err_cyc", qat(err_l, 0), qat(start_l, 0) + LIM + 1);
        chk("t5_rise_cyc", qat(rise_l, 0), qat(start_l, 0) + LIM + 1);
        chk("t5_nstart", start_l.size(), 1);
        chk("t5_data", qat(rdat_l, 0), 255);
        hang = 1'b0;

        clear_logs();
        dly = 2;
        a_cmd_data = 8'h91;
        a_left = 1;
        run_until(1, 40, "t5b_done");
        chk("t5b_nerr", err_l.size(), 0);
        chk("t5b_nstart", start_l.size(), 2);

        // done in the last allowed WAIT cycle wins over the timeout
        clear_logs();
        dly = LIM;
        res_q.push_back(8'h3C);
        a_cmd_data = 8'h20;
        a_left = 1;
        run_until(1, 60, "t5c_done");
        chk("t5c_data", qat(rdat_l, 0), 'h3C);
        chk("t5c_nerr", err_l.size(), 0);

        // done one cycle too late: timeout, late strobe ignored
        clear_logs();
        dly = LIM + 1;
        a_cmd_data = 8'h20;
        a_left = 1;
        run_until(1, 60, "t5d_done");
        chk("t5d_data", qat(rdat_l, 0), 255);
        chk("t5d_nerr", err_l.size(), 1);
        tick();
        chk("t5d_idle", int'(rsp_valid), 0);

        // ena gating
        clear_logs();
        dly = 1;
        ena = 1'b0;
        a_cmd_data = 8'h10;
        a_left = 1;
        repeat (5) tick();
        chk("t6_gated", acc_l.size(), 0);
        ena = 1'b1;
        run_until(1, 20, "t6_done");

        // reset during WAIT, stale done afterwards
        clear_logs();
        dly = 5;
        a_cmd_data = 8'hA0;
        a_left = 1;
        begin
            int k = 0;
            while (start_l.size() == 0 && k < 20) begin
                tick();
                k++;
            end
        end
        chk("t7_started", start_l.size(), 1);
        tick();
        do_reset();
        repeat (8) tick();
        chk("t7_no_rsp", rise_l.size(), 0);
        chk("t7_no_err", err_l.size(), 0);

        // first tie after reset goes to A
        clear_logs();
        dly = 1;
        a_cmd_data = 8'h31;
        b_cmd_data = 8'h42;
        a_left = 1;
        b_left = 1;
        run_until(2, 60, "t8_done");
        chk("t8_src0", qat(src_l, 0), 0);
        chk("t8_src1", qat(src_l, 1), 1);

        // randomized traffic against the model
        clear_logs();
        rnd = 1'b1;
        repeat (3000) tick();
        rnd = 1'b0;
        ena = 1'b1;
        a_left = 0;
        b_left = 0;
        dly = 1;
        begin
            int k = 0;
            while (busy_m && k < 300) begin
                tick();
                k++;
            end
        end
        chk("rnd_drain", int'(busy_m), 0);
        chk("rnd_no_err", err_l.size(), 0);
        chk("rnd_enough", int'(rdat_l.size() >= 20), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
